// File: rtl/mem_subword_ctrl.sv
// mem_subword_ctrl
// Multicycle load/store sequencer between the CPU control unit and a
// word-wide memory port with a ready handshake. Handles byte, halfword
// and word accesses; sub-word stores are done as read-modify-write of the
// containing word. Misaligned requests are rejected before any memory
// strobe is raised, and each memory phase is bounded by TIMEOUT cycles.

module mem_subword_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    // Sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Last counter value that may still wait for mem_ready in a phase;
    // one more cycle without ready means the phase has used TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [7:0]  cnt;

    // Request fields captured at acceptance
    logic        we_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        misaligned;
    logic        accept;
    logic        phase_expired;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Status and strobes are pure state decodes, so they can never glitch
    // together: only one of RD/WR/DONE/ERR is active at a time.
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign err    = (state == ST_ERR);
    assign mem_rd = (state == ST_RD);
    assign mem_wr = (state == ST_WR);

    assign accept        = (state == ST_IDLE) && req;
    assign phase_expired = (cnt == CNT_LAST) && !mem_ready;

    // Alignment check on the live request; size 11 is always rejected
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = |addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it for a load
    always_comb begin
        byte_sel = mem_rdata[7:0];
        half_sel = mem_rdata[15:0];
        load_val = mem_rdata;
        case (lane_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        if (lane_q[1]) begin
            half_sel = mem_rdata[31:16];
        end
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Splice the store data into the addressed lane of the word just read
    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (lane_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end
    end

    // Next-state selection; mem_ready only matters inside RD and WR
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        state_nxt = ST_ERR;
                    end else if (we && (size == SZ_WORD)) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    state_nxt = we_q ? ST_WR : ST_DONE;
                end else if (phase_expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WR: begin
                if (mem_ready) begin
                    state_nxt = ST_DONE;
                end else if (phase_expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any strobe immediately without a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-phase wait counter, cleared whenever the state changes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (state_nxt != state) begin
            cnt <= 8'd0;
        end else if ((state == ST_RD) || (state == ST_WR)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Capture request fields and update the data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            wdata_q   <= 16'd0;
            rdata     <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            if (accept) begin
                we_q     <= we;
                sext_q   <= sext;
                size_q   <= size;
                lane_q   <= addr[1:0];
                wdata_q  <= wdata[15:0];
                mem_addr <= {addr[31:2], 2'b00};
                if (we && (size == SZ_WORD) && !misaligned) begin
                    mem_wdata <= wdata;
                end
            end
            if ((state == ST_RD) && mem_ready) begin
                if (we_q) begin
                    mem_wdata <= merged;
                end else begin
                    rdata <= load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Testbench for mem_subword_ctrl: scenario tasks with a scoreboard of
// expected completions, a behavioural memory with per-phase ready gating,
// and a strobe monitor.

module tb_mem_subword_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Memory model controls
    logic        rd_ok;
    logic        wr_ok;
    logic [31:0] mem_word;

    int total = 0;
    int bad   = 0;

    // Monitor counters
    int          rd_hi = 0;
    int          wr_hi = 0;
    int          wr_acc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        overlap = 1'b0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;

    typedef struct {
        logic        d;
        logic        e;
        logic [31:0] rd;
        int          lat;
        int          busyc;
        logic        to;
    } obs_t;

    typedef struct {
        logic        e;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mem_subword_ctrl #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Zero-wait memory unless the phase is gated off
    assign mem_ready = (mem_rd & rd_ok) | (mem_wr & wr_ok);
    assign mem_rdata = mem_word;

    // Track strobe activity and completion pulses
    always @(posedge clk) begin
        if (mem_rd) rd_hi <= rd_hi + 1;
        if (mem_wr) wr_hi <= wr_hi + 1;
        if (mem_rd && mem_wr) overlap <= 1'b1;
        if (mem_wr && mem_ready) begin
            wr_acc     <= wr_acc + 1;
            last_wdata <= mem_wdata;
            last_waddr <= mem_addr;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    // Issue one request from a negedge with the DUT idle; lat counts the
    // req cycle as cycle 1. Returns one negedge after the done/err cycle.
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output obs_t o);
        logic found;
        o = '{default: 0};
        found = 1'b0;
        we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= 60 && !found; k++) begin
            if (busy) o.busyc++;
            if (done || err) begin
                o.d = done; o.e = err; o.rd = rdata; o.lat = k + 1;
                found = 1'b1;
            end
            @(negedge clk);
        end
        o.to = !found;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'd0; wdata = 32'd0; rd_ok = 1'b1; wr_ok = 1'b1; mem_word = 32'd0;
        repeat (3) @(negedge clk);
        total++; if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin bad++;
            $display("[TB] FAIL reset_ctl: got %b want 00000", {busy, done, err, mem_rd, mem_wr}); end
        total++; if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        total++; if (mem_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin bad++;
            $display("[TB] FAIL idle_ctl: got %b want 00000", {busy, done, err, mem_rd, mem_wr}); end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] m;
        logic [31:0] x;
    } ld_t;

    task automatic test_loads();
        ld_t  v[8];
        obs_t o;
        exp_t e;
        int   wr0;
        v[0] = '{32'h1003, 2'b00, 1'b1, 32'h80FF1234, 32'hFFFFFF80};
        v[1] = '{32'h2002, 2'b01, 1'b0, 32'hBEEF0001, 32'h0000BEEF};
        v[2] = '{32'h2002, 2'b01, 1'b1, 32'hBEEF0001, 32'hFFFFBEEF};
        v[3] = '{32'h1001, 2'b00, 1'b1, 32'h80FF1234, 32'h00000012};
        v[4] = '{32'h1002, 2'b00, 1'b1, 32'h80FF1234, 32'hFFFFFFFF};
        v[5] = '{32'h2000, 2'b01, 1'b1, 32'h12348765, 32'hFFFF8765};
        v[6] = '{32'h3000, 2'b10, 1'b1, 32'h80FF1234, 32'h80FF1234};
        v[7] = '{32'h1000, 2'b00, 1'b0, 32'h000000F0, 32'h000000F0};
        rd_ok = 1'b1; wr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_word = v[i].m;
            wr0 = wr_acc;
            e.e = 1'b0; e.rd = v[i].x; e.lat = 3;
            sb.push_back(e);
            run_txn(1'b0, v[i].sz, v[i].sx, v[i].a, 32'h0, o);
            e = sb.pop_front();
            total++; if (o.to) begin bad++; $display("[TB] FAIL load%0d wait: no done/err, want done", i); end
            total++; if (o.e !== e.e || o.d !== !e.e) begin bad++;
                $display("[TB] FAIL load%0d status: got done=%b err=%b want done=1 err=0", i, o.d, o.e); end
            total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL load%0d latency: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL load%0d rdata: got %h want %h", i, o.rd, e.rd); end
            total++; if (mem_addr !== (v[i].a & 32'hFFFF_FFFC)) begin bad++;
                $display("[TB] FAIL load%0d mem_addr: got %h want %h", i, mem_addr, v[i].a & 32'hFFFF_FFFC); end
            total++; if (wr_acc !== wr0) begin bad++; $display("[TB] FAIL load%0d writes: got %0d want 0", i, wr_acc - wr0); end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] m;
        logic [31:0] x;
        int          lat;
    } st_t;

    task automatic test_stores();
        st_t         v[5];
        obs_t        o;
        exp_t        e;
        int          wr0;
        logic [31:0] rprev;
        v[0] = '{32'h11, 2'b00, 32'h000000AA, 32'h44332211, 32'h4433AA11, 4};
        v[1] = '{32'h22, 2'b01, 32'h12345678, 32'hAABBCCDD, 32'h5678CCDD, 4};
        v[2] = '{32'h30, 2'b10, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 3};
        v[3] = '{32'h0C, 2'b00, 32'h0000007E, 32'h11223344, 32'h1122337E, 4};
        v[4] = '{32'h1C, 2'b01, 32'hFFFF5A5A, 32'hCAFEF00D, 32'hCAFE5A5A, 4};
        rd_ok = 1'b1; wr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_word = v[i].m;
            wr0 = wr_acc;
            rprev = rdata;
            e.e = 1'b0; e.rd = v[i].x; e.lat = v[i].lat;
            sb.push_back(e);
            run_txn(1'b1, v[i].sz, 1'b0, v[i].a, v[i].wd, o);
            e = sb.pop_front();
            total++; if (o.to || o.d !== 1'b1 || o.e !== 1'b0) begin bad++;
                $display("[TB] FAIL store%0d status: got done=%b err=%b to=%b want done=1", i, o.d, o.e, o.to); end
            total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL store%0d latency: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (last_wdata !== e.rd) begin bad++; $display("[TB] FAIL store%0d mem_wdata: got %h want %h", i, last_wdata, e.rd); end
            total++; if (last_waddr !== (v[i].a & 32'hFFFF_FFFC)) begin bad++;
                $display("[TB] FAIL store%0d waddr: got %h want %h", i, last_waddr, v[i].a & 32'hFFFF_FFFC); end
            total++; if (wr_acc - wr0 !== 1) begin bad++; $display("[TB] FAIL store%0d writes: got %0d want 1", i, wr_acc - wr0); end
            total++; if (rdata !== rprev) begin bad++; $display("[TB] FAIL store%0d rdata_hold: got %h want %h", i, rdata, rprev); end
        end
    endtask

    task automatic test_misalign();
        logic        w[4];
        logic [1:0]  sz[4];
        logic [31:0] a[4];
        obs_t        o;
        exp_t        e;
        int          rd0, wr0;
        w[0] = 1'b1; sz[0] = 2'b01; a[0] = 32'h5;
        w[1] = 1'b0; sz[1] = 2'b10; a[1] = 32'h6;
        w[2] = 1'b0; sz[2] = 2'b11; a[2] = 32'h8;
        w[3] = 1'b1; sz[3] = 2'b10; a[3] = 32'h102;
        rd_ok = 1'b1; wr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd0 = rd_hi; wr0 = wr_hi;
            e.e = 1'b1; e.rd = 32'd0; e.lat = 2;
            sb.push_back(e);
            run_txn(w[i], sz[i], 1'b0, a[i], 32'h12345678, o);
            e = sb.pop_front();
            total++; if (o.to || o.e !== e.e || o.d !== 1'b0) begin bad++;
                $display("[TB] FAIL mis%0d status: got done=%b err=%b to=%b want err=1", i, o.d, o.e, o.to); end
            total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL mis%0d latency: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (o.busyc !== 1) begin bad++; $display("[TB] FAIL mis%0d busy_len: got %0d want 1", i, o.busyc); end
            total++; if (rd_hi !== rd0 || wr_hi !== wr0) begin bad++;
                $display("[TB] FAIL mis%0d strobes: got rd=%0d wr=%0d want 0", i, rd_hi - rd0, wr_hi - wr0); end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        int   rd0, wr0, d0;
        rd_ok = 1'b0; wr_ok = 1'b1; mem_word = 32'h11111111;
        rd0 = rd_hi; d0 = done_cnt;
        e.e = 1'b1; e.rd = 32'd0; e.lat = 18;
        sb.push_back(e);
        run_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, o);
        e = sb.pop_front();
        total++; if (o.to || o.e !== 1'b1 || o.d !== 1'b0) begin bad++;
            $display("[TB] FAIL to_rd status: got done=%b err=%b to=%b want err=1", o.d, o.e, o.to); end
        total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL to_rd latency: got %0d want %0d", o.lat, e.lat); end
        total++; if (rd_hi - rd0 !== 16) begin bad++; $display("[TB] FAIL to_rd strobe_len: got %0d want 16", rd_hi - rd0); end
        total++; if (done_cnt !== d0) begin bad++; $display("[TB] FAIL to_rd done_pulses: got %0d want 0", done_cnt - d0); end

        rd_ok = 1'b1; wr_ok = 1'b0;
        wr0 = wr_hi;
        run_txn(1'b1, 2'b10, 1'b0, 32'h50, 32'h1, o);
        total++; if (o.to || o.e !== 1'b1 || o.d !== 1'b0) begin bad++;
            $display("[TB] FAIL to_wr status: got done=%b err=%b to=%b want err=1", o.d, o.e, o.to); end
        total++; if (wr_hi - wr0 !== 16) begin bad++; $display("[TB] FAIL to_wr strobe_len: got %0d want 16", wr_hi - wr0); end

        rd_ok = 1'b1; wr_ok = 1'b1; mem_word = 32'h13572468;
        e.e = 1'b0; e.rd = 32'h13572468; e.lat = 3;
        sb.push_back(e);
        run_txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, o);
        e = sb.pop_front();
        total++; if (o.to || o.d !== 1'b1 || o.lat !== e.lat) begin bad++;
            $display("[TB] FAIL to_recover: got done=%b lat=%0d want done=1 lat=%0d", o.d, o.lat, e.lat); end
        total++; if (o.rd !== e.rd) begin bad++; $display("[TB] FAIL to_recover rdata: got %h want %h", o.rd, e.rd); end
    endtask

    task automatic test_reset_midop();
        int d0, e0;
        rd_ok = 1'b1; wr_ok = 1'b0; mem_word = 32'h44332211;
        d0 = done_cnt; e0 = err_cnt;
        we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h11; wdata = 32'hAA; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("[TB] FAIL rstmid in_wr: got mem_wr=%b want 1", mem_wr); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin bad++;
            $display("[TB] FAIL rstmid ctl: got %b want 00000", {busy, done, err, mem_rd, mem_wr}); end
        total++; if (rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++;
            $display("[TB] FAIL rstmid data: got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (done_cnt !== d0 || err_cnt !== e0) begin bad++;
            $display("[TB] FAIL rstmid pulses: got done=%0d err=%0d want 0", done_cnt - d0, err_cnt - e0); end
        wr_ok = 1'b1;
    endtask

    task automatic test_overlap();
        logic found;
        int   d0;
        exp_t e;
        rd_ok = 1'b0; wr_ok = 1'b1; mem_word = 32'h0BADF00D;
        d0 = done_cnt;
        e.e = 1'b0; e.rd = 32'h0BADF00D; e.lat = 0;
        sb.push_back(e);
        we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h100; req = 1'b1;
        @(negedge clk);
        addr = 32'h207; size = 2'b00; sext = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 32'h100 || busy !== 1'b1) begin bad++;
            $display("[TB] FAIL overlap addr: got %h busy=%b want 00000100 busy=1", mem_addr, busy); end
        @(negedge clk);
        rd_ok = 1'b1; req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        e = sb.pop_front();
        total++; if (!found) begin bad++; $display("[TB] FAIL overlap wait: no done, want done"); end
        total++; if (rdata !== e.rd) begin bad++; $display("[TB] FAIL overlap rdata: got %h want %h", rdata, e.rd); end
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done_cnt - d0 !== 1) begin bad++;
            $display("[TB] FAIL overlap queued: got busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        rd_ok = 1'b1; wr_ok = 1'b1; mem_word = 32'h80FF1234;
        e.e = 1'b0; e.rd = 32'h00000034; e.lat = 3; sb.push_back(e);
        e.e = 1'b0; e.rd = 32'hFFFF80FF; e.lat = 3; sb.push_back(e);
        e.e = 1'b0; e.rd = 32'h80FF5634; e.lat = 4; sb.push_back(e);
        run_txn(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, o);
        e = sb.pop_front();
        total++; if (o.to || o.d !== 1'b1 || o.rd !== e.rd || o.lat !== e.lat) begin bad++;
            $display("[TB] FAIL b2b_a: got done=%b rdata=%h lat=%0d want 1 %h %0d", o.d, o.rd, o.lat, e.rd, e.lat); end
        run_txn(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, o);
        e = sb.pop_front();
        total++; if (o.to || o.d !== 1'b1 || o.rd !== e.rd || o.lat !== e.lat) begin bad++;
            $display("[TB] FAIL b2b_b: got done=%b rdata=%h lat=%0d want 1 %h %0d", o.d, o.rd, o.lat, e.rd, e.lat); end
        run_txn(1'b1, 2'b00, 1'b0, 32'h1001, 32'h56, o);
        e = sb.pop_front();
        total++; if (o.to || o.d !== 1'b1 || last_wdata !== e.rd || o.lat !== e.lat) begin bad++;
            $display("[TB] FAIL b2b_c: got done=%b wdata=%h lat=%0d want 1 %h %0d", o.d, last_wdata, o.lat, e.rd, e.lat); end
        total++; if (overlap !== 1'b0) begin bad++; $display("[TB] FAIL strobe_overlap: got %b want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_midop();
        test_overlap();
        test_back_to_back();
        total++; if (sb.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_left: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
